// File: rtl/ring_wr_cntrl_pkg.sv
// ring_wr_cntrl_pkg: state codes and default widths shared
// by the ring-buffer write and readout address controllers.
package ring_wr_cntrl_pkg;

  localparam int SIZE_DEF = 12;
  localparam int DW_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    ARMED  = 3'd2,
    POST   = 3'd3,
    FROZEN = 3'd4
  } wr_state_t;

  function automatic logic is_busy(input wr_state_t s);
    return (s == FILL) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/ring_wr_cntrl_ptr.sv
// ring_ptr: modulo-2^SIZE write pointer with increment
// enable and synchronous clear.
module ring_ptr
  import ring_wr_cntrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            sysclk,
  input  logic            clr,
  input  logic            inc,
  output logic [SIZE-1:0] ptr,
  output logic [SIZE-1:0] ptr_nxt
);

  assign ptr_nxt = ptr + SIZE'(inc);

  // pointer register; natural overflow gives the ring wrap
  always_ff @(posedge sysclk) begin
    if (clr) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/ring_wr_cntrl.sv
// ring_wr_cntrl: ring-buffer write side. Optional trigger
// timestamp output enabled by TRIG_TIMESTAMP_EN.
module ring_wr_cntrl
  import ring_wr_cntrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic            sysclk,
  input  logic            rst,
  input  logic            enable,
  input  logic            adc_valid,
  input  logic [DW-1:0]   adc_data,
  input  logic            trigger,
  input  logic [SIZE-1:0] pretrig_i,
  input  logic [SIZE-1:0] posttrig_i,
  input  logic            rd_request,
  output logic            wr_en,
  output logic [SIZE-1:0] wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic [SIZE-1:0] ain,
  output logic            data_ready,
  output logic            busy
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]     trig_time
`endif
);

  wr_state_t       st, nxt;
  logic [SIZE-1:0] ptr, ptr_nxt;
  logic [SIZE-1:0] fill_cnt;
  logic [SIZE-1:0] post_cnt;
  logic            seen;
  logic            wr_go;
  logic            accept;

  assign busy   = is_busy(st);
  assign wr_go  = busy & adc_valid;
  assign accept = (st == ARMED) & enable & trigger;

  ring_ptr #(.SIZE(SIZE)) u_ptr (
    .sysclk  (sysclk),
    .clr     (rst),
    .inc     (wr_go),
    .ptr     (ptr),
    .ptr_nxt (ptr_nxt)
  );

  // next-state decode; enable low always wins
  always_comb begin
    nxt = st;
    if (!enable) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE:   nxt = FILL;
        FILL:   if (fill_cnt >= pretrig_i) nxt = ARMED;
        ARMED:  if (trigger) begin
                  if (posttrig_i == '0) nxt = FROZEN;
                  else                  nxt = POST;
                end
        POST:   if (adc_valid && post_cnt == SIZE'(1))
                  nxt = FROZEN;
        FROZEN: if (seen && !rd_request) nxt = FILL;
        default: nxt = IDLE;
      endcase
    end
  end

  // state, write port, counters and frozen head pointer
  always_ff @(posedge sysclk) begin
    if (rst) begin
      st         <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      ain        <= '0;
      data_ready <= 1'b0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      seen       <= 1'b0;
    end else begin
      st         <= nxt;
      wr_en      <= wr_go;
      data_ready <= (nxt == FROZEN);
      if (wr_go) begin
        wr_addr <= ptr;
        wr_data <= adc_data;
      end
      if (nxt == FROZEN && st != FROZEN)
        ain <= ptr_nxt;
      if (nxt == FILL && st != FILL)
        fill_cnt <= '0;
      else if (st == FILL && adc_valid && fill_cnt != '1)
        fill_cnt <= fill_cnt + SIZE'(1);
      if (accept)
        post_cnt <= posttrig_i;
      else if (st == POST && adc_valid)
        post_cnt <= post_cnt - SIZE'(1);
      if (st != FROZEN) seen <= 1'b0;
      else if (rd_request) seen <= 1'b1;
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  // free-running cycle count, latched on trigger acceptance
  always_ff @(posedge sysclk) begin
    if (rst) begin
      ts_cnt    <= '0;
      trig_time <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (accept) trig_time <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ring_wr_cntrl.sv
// tb_ring_wr_cntrl: directed plus randomized run against a
// phase-level reference model and a shadow RAM of the ring.
module tb_ring_wr_cntrl;

  localparam int SZ    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 1 << SZ;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          adc_valid = 1'b0;
  logic [W-1:0]  adc_data = '0;
  logic          trigger = 1'b0;
  logic [SZ-1:0] pretrig_i = '0;
  logic [SZ-1:0] posttrig_i = '0;
  logic          rd_request = 1'b0;
  logic          wr_en;
  logic [SZ-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [SZ-1:0] ain;
  logic          data_ready;
  logic          busy;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]   trig_time;
`endif

  always #5 sysclk = ~sysclk;

  ring_wr_cntrl #(.SIZE(SZ), .DW(W)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .enable     (enable),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trigger    (trigger),
    .pretrig_i  (pretrig_i),
    .posttrig_i (posttrig_i),
    .rd_request (rd_request),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ain        (ain),
    .data_ready (data_ready),
    .busy       (busy)
`ifdef TRIG_TIMESTAMP_EN
    ,
    .trig_time  (trig_time)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: phase name, sample counts, ring position
  string        ph = "idle";
  int           m_ptr, m_ain, filled, left, ts, tt;
  bit           saw, e_we, prev_dr;
  int           e_addr, e_data;
  int           freezes = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] ram[DEPTH];

  function automatic bit live(input string p);
    return p == "fill" || p == "armed" || p == "post";
  endfunction

  task automatic step(input bit r, input bit en, input bit v,
                      input bit trg, input bit rd,
                      input logic [W-1:0] d);
    bit    wr;
    string nx;
    int    idx, n;
    rst = r; enable = en; adc_valid = v;
    trigger = trg; rd_request = rd; adc_data = d;
    if (r) begin
      ph = "idle"; m_ptr = 0; m_ain = 0; filled = 0;
      left = 0; saw = 0; e_we = 0; e_addr = 0;
      e_data = 0; ts = 0; tt = 0;
      hist.delete();
    end else begin
      wr = v && live(ph);
      e_we = wr;
      if (wr) begin
        e_addr = m_ptr;
        e_data = int'(d);
        hist.push_back(d);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      nx = ph;
      if (!en) nx = "idle";
      else if (ph == "idle") nx = "fill";
      else if (ph == "fill") begin
        if (filled >= int'(pretrig_i)) nx = "armed";
      end else if (ph == "armed") begin
        if (trg) begin
          tt = ts;
          left = int'(posttrig_i);
          if (left == 0) nx = "frozen";
          else           nx = "post";
        end
      end else if (ph == "post") begin
        if (v && left == 1) nx = "frozen";
      end else if (ph == "frozen") begin
        if (saw && !rd) nx = "fill";
      end
      if (ph == "fill" && wr && filled < DEPTH - 1) filled++;
      if (ph == "post" && wr) left--;
      if (ph == "frozen" && rd) saw = 1;
      m_ptr = (m_ptr + int'(wr)) % DEPTH;
      if (nx == "frozen" && ph != "frozen") m_ain = m_ptr;
      if (nx == "fill" && ph != "fill") filled = 0;
      if (nx != "frozen") saw = 0;
      ts++;
      ph = nx;
    end
    @(posedge sysclk);
    #1;
    if (wr_en) ram[wr_addr] = wr_data;
    chk("wr_en", wr_en, e_we);
    if (e_we) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    if (r) begin
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
    end
    chk("ain", ain, m_ain);
    chk("data_ready", data_ready, ph == "frozen");
    chk("busy", busy, live(ph));
`ifdef TRIG_TIMESTAMP_EN
    chk("trig_time", trig_time, tt);
`endif
    if (ph == "frozen" && !prev_dr) begin
      freezes++;
      n = hist.size();
      for (int k = 0; k < n; k++) begin
        idx = (m_ain - 1 - k + 2 * DEPTH) % DEPTH;
        chk("ring_content", ram[idx], hist[n - 1 - k]);
      end
    end
    prev_dr = (ph == "frozen");
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);

    // basic capture: pretrig 3, posttrig 2, trigger on 5th sample
    pretrig_i = 4'd3; posttrig_i = 4'd2;
    step(0, 1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 10; i++)
      step(0, 1, 1, i == 5, 0, 8'(8'h10 + i));
    chk("A_ain", ain, 7);
    chk("A_ready", data_ready, 1);
    chk("A_wr_en", wr_en, 0);

    // readout handshake: 10 cycles high then low
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1, 8'h55);
    chk("C_held", data_ready, 1);
    step(0, 1, 1, 0, 0, 8'h56);
    chk("C_ready", data_ready, 0);
    chk("C_busy", busy, 1);

    // trigger during fill ignored, then accepted; wraps ring
    pretrig_i = 4'd8; posttrig_i = 4'd4;
    for (int i = 0; i < 14; i++)
      step(0, 1, 1, i == 3 || i == 12, 0, 8'(8'h80 + i));
    idle_cyc(2);
    step(0, 1, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);

    // posttrig 0: straight to frozen
    pretrig_i = 4'd1; posttrig_i = 4'd0;
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, i == 4, 0, 8'(8'hA0 + i));
    step(0, 1, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);

    // enable drop during post, then rst during post
    pretrig_i = 4'd1; posttrig_i = 4'd9;
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, i == 3, 0, 8'(8'hC0 + i));
    step(0, 0, 1, 0, 0, 8'hCF);
    step(0, 0, 1, 0, 0, 8'hCE);
    chk("E_busy", busy, 0);
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, i == 3, 0, 8'(8'hD0 + i));
    step(1, 1, 1, 0, 0, 8'hDF);
    chk("E_rst_ain", ain, 0);
    chk("E_rst_wr_en", wr_en, 0);

    // randomized run
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(39) == 0) pretrig_i = 4'($urandom);
      if ($urandom_range(39) == 0) posttrig_i = 4'($urandom);
      step($urandom_range(299) == 0,
           $urandom_range(59) != 0,
           $urandom_range(9) < 7,
           $urandom_range(7) == 0,
           $urandom_range(2) == 0,
           8'($urandom));
    end
    chk("freezes_seen", freezes > 10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
